// File: rtl/sha256_pkg.sv
// sha256_pkg: shared FSM encoding, round constants, IV and bit-mixing helpers for the folded SHA-256 core
package sha256_pkg;
  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_ADD, S_DONE} fsm_t;
  typedef logic [0:7][31:0] work_t;
  typedef logic [0:15][31:0] blk_t;
  localparam work_t SHA_IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [0:63][31:0] SHA_K = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
  function automatic bit unroll_ok(input int u);
    return u == 1 || u == 2 || u == 4 || u == 8 || u == 16;
  endfunction
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [31:0] big_s0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction
  function automatic logic [31:0] big_s1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction
  function automatic logic [31:0] sml_s0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction
  function automatic logic [31:0] sml_s1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction
endpackage

// File: rtl/sha256_folded_core_if.sv
// sha256_folded_core_if: job offer and result handshake between a producer and the SHA-256 core
interface sha256_folded_core_if;
  logic in_valid, in_ready, mode_double, flush, valid_out, out_ready;
  logic [255:0] midstate_in, digest_out;
  logic [511:0] block_in;
  modport master (
    output in_valid, mode_double, midstate_in, block_in, flush, out_ready,
    input in_ready, valid_out, digest_out
  );
  modport slave (
    input in_valid, mode_double, midstate_in, block_in, flush, out_ready,
    output in_ready, valid_out, digest_out
  );
endinterface

// File: rtl/sha256_round.sv
// sha256_round: one combinational SHA-256 compression round
module sha256_round
  import sha256_pkg::*;
(
  input  work_t       i_s,
  input  logic [31:0] i_w,
  input  logic [31:0] i_k,
  output work_t       o_s
);
  logic [31:0] w_t1, w_t2;
  assign w_t1 = i_s[7] + big_s1(i_s[4]) + ((i_s[4] & i_s[5]) ^ (~i_s[4] & i_s[6])) + i_k + i_w;
  assign w_t2 = big_s0(i_s[0]) + ((i_s[0] & i_s[1]) ^ (i_s[0] & i_s[2]) ^ (i_s[1] & i_s[2]));
  assign o_s = {w_t1 + w_t2, i_s[0], i_s[1], i_s[2], i_s[3] + w_t1, i_s[4], i_s[5], i_s[6]};
endmodule

// File: rtl/sha256_folded_core.sv
// sha256_folded_core: iterative SHA-256 / SHA-256d compression computing UNROLL rounds per clock
module sha256_folded_core
  import sha256_pkg::*;
#(
  parameter int UNROLL  = 1,
  parameter bit OUT_REG = 1
) (
  input logic CLK,
  input logic RST,
  sha256_folded_core_if.slave bus
);
  if (!unroll_ok(UNROLL)) begin : gen_bad_unroll
    $error("sha256_folded_core: UNROLL must be 1, 2, 4, 8 or 16");
  end
  localparam logic [5:0] LAST = 6'(64 - UNROLL);
  fsm_t r_state, w_next;
  logic r_live, r_pass, r_dbl, w_acc, w_fin;
  logic [5:0] r_cnt;
  work_t r_h, r_s, w_rnd, w_sum;
  blk_t r_w, w_win;
  logic [31:0] w_ext [16+UNROLL];
  assign w_acc = bus.in_valid && bus.in_ready && !bus.flush;
  assign w_fin = r_state == S_ADD && !(r_dbl && !r_pass);
  // r_live keeps in_ready low until the first edge after reset release
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      r_state <= S_IDLE;
      r_live  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_live  <= 1'b1;
    end
  always_comb
    w_next = bus.flush ? S_IDLE :
             r_state == S_IDLE  ? (w_acc ? S_ROUND : S_IDLE) :
             r_state == S_ROUND ? (r_cnt == LAST ? S_ADD : S_ROUND) :
             r_state == S_ADD   ? (w_fin ? S_DONE : S_ROUND) :
             (bus.out_ready ? S_IDLE : S_DONE);
  always_comb begin
    bus.in_ready  = r_live && r_state == S_IDLE;
    bus.valid_out = r_state == S_DONE;
  end
  // window holds W[t..t+15]; extend by UNROLL words and slide
  always_comb begin
    for (int i = 0; i < 16; i++) w_ext[i] = r_w[i];
    for (int i = 16; i < 16 + UNROLL; i++)
      w_ext[i] = sml_s1(w_ext[i-2]) + w_ext[i-7] + sml_s0(w_ext[i-15]) + w_ext[i-16];
    for (int i = 0; i < 16; i++) w_win[i] = w_ext[i+UNROLL];
  end
  for (genvar g = 0; g < UNROLL; g++) begin : gen_rnd
    localparam logic [5:0] OFF = 6'(g);
    work_t w_in, w_out;
    if (g == 0) begin : gen_head
      assign w_in = r_s;
    end else begin : gen_tail
      assign w_in = gen_rnd[g-1].w_out;
    end
    sha256_round u_round (.i_s(w_in), .i_w(w_ext[g]), .i_k(SHA_K[r_cnt + OFF]), .o_s(w_out));
  end
  assign w_rnd = gen_rnd[UNROLL-1].w_out;
  always_comb
    for (int i = 0; i < 8; i++) w_sum[i] = r_h[i] + r_s[i];
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      r_h    <= '0;
      r_s    <= '0;
      r_w    <= '0;
      r_cnt  <= '0;
      r_pass <= 1'b0;
      r_dbl  <= 1'b0;
    end else if (w_acc) begin
      r_h    <= bus.midstate_in;
      r_s    <= bus.midstate_in;
      r_w    <= bus.block_in;
      r_cnt  <= '0;
      r_pass <= 1'b0;
      r_dbl  <= bus.mode_double;
    end else if (r_state == S_ROUND) begin
      r_s   <= w_rnd;
      r_w   <= w_win;
      r_cnt <= r_cnt + 6'(UNROLL);
    end else if (r_state == S_ADD && !w_fin) begin
      r_h    <= SHA_IV;
      r_s    <= SHA_IV;
      r_w    <= {w_sum, 32'h80000000, 192'h0, 32'h00000100};
      r_pass <= 1'b1;
    end
  // working state and chaining value stay frozen in DONE, so the sum is stable there
  if (OUT_REG) begin : gen_oreg
    logic [255:0] r_digest;
    always_ff @(posedge CLK or negedge RST)
      if (!RST) r_digest <= '0;
      else if (w_fin) r_digest <= w_sum;
    assign bus.digest_out = r_digest;
  end else begin : gen_ocomb
    assign bus.digest_out = w_sum;
  end
endmodule

// File: tb/tb_sha256_folded_core.sv
// tb_sha256_folded_core: scoreboard bench running every UNROLL (plus an unregistered-output build) in parallel
module tb_sha256_folded_core;
  typedef struct {
    logic [255:0] dig;
    int           rise;
  } exp_t;
  localparam logic [255:0] IV     = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [511:0] ABC    = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] EMP    = {32'h80000000, 480'h0};
  localparam logic [255:0] D_ABC  = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] D_ABC2 = 256'h4f8b42c22dd3729b519ba6f68d2da7cc5b2d606d05daed5ad5128cc03e6c6358;
  localparam logic [255:0] D_E    = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] D_E2   = 256'h5df6e0e2761359d30a8275058e299fcc0381534545f55cf43e41983f5d4c9456;
  localparam logic [6:0]   DBL    = 7'b0001010;
  localparam logic [511:0] BLK [7] = '{ABC, ABC, EMP, EMP, ABC, EMP, ABC};
  localparam logic [255:0] DIG [7] = '{D_ABC, D_ABC2, D_E, D_E2, D_ABC, D_E, D_ABC};
  logic clk = 1'b0;
  int n_vec = 0, n_err = 0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  for (genvar g = 0; g < 6; g++) begin : gen_cfg
    localparam int U  = 1 << (g == 5 ? 3 : g);
    localparam int N  = 64 / U + 1;
    localparam int FL = (64 / U < 20) ? 64 / U : 20;
    sha256_folded_core_if bus ();
    logic rst_n;
    int cyc = 0, hold = 0, ndone = 0;
    bit fin = 1'b0;
    exp_t q[$];
    sha256_folded_core #(.UNROLL(U), .OUT_REG(g != 5)) dut (.CLK(clk), .RST(rst_n), .bus(bus));
    always @(posedge clk) cyc <= cyc + 1;
    initial begin
      exp_t e;
      rst_n = 1'b0;
      bus.in_valid = 1'b0;
      bus.flush = 1'b0;
      bus.mode_double = 1'b0;
      bus.midstate_in = '0;
      bus.block_in = '0;
      repeat (3) @(negedge clk);
      check("rst_valid", bus.valid_out, 0);
      check("rst_ready", bus.in_ready, 0);
      check("rst_digest", bus.digest_out, 0);
      rst_n = 1'b1;
      #1 check("ready_before_edge", bus.in_ready, 0);
      @(negedge clk);
      check("ready_after_edge", bus.in_ready, 1);
      for (int i = 0; i < 7; i++) begin
        if (i == 5) begin
          bus.in_valid = 1'b1;
          bus.mode_double = 1'b0;
          bus.midstate_in = IV;
          bus.block_in = ABC;
          @(negedge clk);
          check("flush_busy", bus.in_ready, 0);
          repeat (FL - 1) @(negedge clk);
          bus.flush = 1'b1;
          @(negedge clk);
          bus.flush = 1'b0;
          bus.in_valid = 1'b0;
          check("flush_idle", bus.in_ready, 1);
          check("flush_valid", bus.valid_out, 0);
          repeat (2 * N) @(negedge clk);
          check("flush_no_result", ndone, 5);
        end
        if (i == 6) begin
          bus.in_valid = 1'b1;
          bus.mode_double = 1'b1;
          bus.midstate_in = IV;
          bus.block_in = ABC;
          @(negedge clk);
          bus.in_valid = 1'b0;
          repeat (N + 1) @(negedge clk);
          check("pass2_busy", bus.in_ready, 0);
          #2 rst_n = 1'b0;
          #1;
          check("async_valid", bus.valid_out, 0);
          check("async_ready", bus.in_ready, 0);
          check("async_digest", bus.digest_out, 0);
          @(negedge clk);
          rst_n = 1'b1;
          @(negedge clk);
          check("rerst_ready", bus.in_ready, 1);
        end
        check("accept_ready", bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.mode_double = DBL[i];
        bus.midstate_in = IV;
        bus.block_in = BLK[i];
        hold = (i == 4) ? 10 : 0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        e.dig = DIG[i];
        e.rise = cyc + (DBL[i] ? 2 * N : N);
        q.push_back(e);
        for (int c = 0; c < 400 && ndone <= i; c++) @(negedge clk);
        check("job_done", ndone, i + 1);
      end
      fin = 1'b1;
    end
    initial begin
      exp_t m;
      logic [255:0] d;
      bus.out_ready = 1'b0;
      forever begin
        @(negedge clk);
        if (rst_n && bus.valid_out) begin
          check("result_expected", q.size() != 0, 1);
          if (q.size() != 0) begin
            m = q.pop_front();
            check("rise_edge", cyc, m.rise);
            check("digest", bus.digest_out, m.dig);
          end
          d = bus.digest_out;
          repeat (hold) begin
            @(negedge clk);
            check("hold_valid", bus.valid_out, 1);
            check("hold_digest", bus.digest_out, d);
            check("hold_busy", bus.in_ready, 0);
          end
          bus.out_ready = 1'b1;
          @(negedge clk);
          bus.out_ready = 1'b0;
          check("consumed", bus.valid_out, 0);
          check("ready_again", bus.in_ready, 1);
          ndone++;
        end
      end
    end
  end
  initial begin
    for (int c = 0; c < 30000 && !(gen_cfg[0].fin && gen_cfg[1].fin && gen_cfg[2].fin &&
                                   gen_cfg[3].fin && gen_cfg[4].fin && gen_cfg[5].fin); c++)
      @(negedge clk);
    check("all_done", {gen_cfg[5].fin, gen_cfg[4].fin, gen_cfg[3].fin, gen_cfg[2].fin, gen_cfg[1].fin, gen_cfg[0].fin}, 6'h3f);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/sha256_folded_core.md
SHA256_FOLDED_CORE -- requirements
Module: sha256_folded_core

Interface
REQ-001 SHALL have parameter UNROLL, default 1, meaning SHA-256 rounds computed per clock; legal values 1, 2, 4, 8, 16.
REQ-002 SHALL have parameter OUT_REG, default 1, meaning digest_out is registered (1) or taken directly from the final-add logic (0).
REQ-003 SHALL have port CLK  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port RST  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  job offered.
REQ-006 SHALL have port in_ready  output  1  core can accept a job.
REQ-007 SHALL have port mode_double  input  1  sampled on accept; 1 selects SHA256d (second pass over the first digest).
REQ-008 SHALL have port midstate_in  input  256  chaining value H0..H7, H0 in [255:224].
REQ-009 SHALL have port block_in  input  512  message block W0..W15, W0 in [511:480].
REQ-010 SHALL have port flush  input  1  synchronous abort.
REQ-011 SHALL have port valid_out  output  1  digest_out holds a finished result.
REQ-012 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-013 SHALL have port digest_out  output  256  result, H0 in [255:224].

Function
REQ-014 SHALL implement states IDLE, ROUND, ADD and DONE, plus a pass flag (0 = first pass, 1 = second pass).
REQ-015 SHALL assert in_ready only in IDLE; a job is accepted on an edge with in_valid && in_ready, latching midstate_in, block_in and mode_double.
REQ-016 SHALL, in ROUND, apply UNROLL FIPS 180-4 rounds per cycle with the message schedule expanded in a 16-word sliding window, advancing the round counter by UNROLL; after 64/UNROLL cycles it SHALL go to ADD.
REQ-017 SHALL, in ADD, form the digest as the per-word mod-2^32 sum of the chaining value and the working variables.
REQ-018 SHALL, in ADD on the first pass with the mode_double latch set, load a new block and start pass 2 in ROUND. The new block is the digest, then 0x80000000, six zero words, then 0x00000100; the chaining value is the standard IV 6A09E667..5BE0CD19.
REQ-019 SHALL otherwise go from ADD to DONE with valid_out=1.
REQ-020 SHALL make valid_out rise exactly N=64/UNROLL+1 edges after the accept edge in single mode, and 2N edges after it in double mode (for example 65 and 130 edges at UNROLL=1).
REQ-021 SHALL hold valid_out and digest_out stable in DONE until an edge with out_ready=1, then return to IDLE with valid_out=0.
REQ-022 SHALL not accept a job in the same cycle that a result is consumed; in_ready rises one cycle after consumption.
REQ-023 SHALL, on flush=1 at an edge in any state, return to IDLE with valid_out=0 and discard the job; flush has priority over accept and over out_ready.
REQ-024 SHALL ignore in_valid outside IDLE and ignore out_ready outside DONE.
REQ-025 SHALL, when OUT_REG=0, present digest_out combinationally from the stored result; timing to valid_out is unchanged.

Reset
REQ-026 SHALL, while RST=0, force state IDLE, pass 0, round counter 0, valid_out 0, in_ready 0, digest_out 0 and all datapath registers 0.
REQ-027 SHALL assert in_ready on the first edge after RST deasserts; a reset mid-job abandons that job with no output.

Structure
REQ-028 SHALL place the 64 round constants K, the IV, the state encoding and the legal-UNROLL check in shared package sha256_pkg; an illegal UNROLL SHALL be an elaboration error.
REQ-029 SHALL instantiate UNROLL copies of a single combinational sub-module, sha256_round (one round: working state in, W and K in, working state out).

Verification
REQ-030 SHALL cover: single mode, UNROLL=1, midstate=IV, block="abc" padded (0x61626380, zeros, 0x00000018) -> valid_out rises 65 edges after accept, digest BA7816BF8F01CFEA414140DE5DAE2223B00361A396177A9CB410FF61F20015AD.
REQ-031 SHALL cover: double mode, same "abc" block, UNROLL=4 -> valid_out rises 34 edges after accept, digest 4F8B42C22DD3729B519BA6F68D2DA7CC5B2D606D05DAED5AD5128CC03E6C6358.
REQ-032 SHALL cover: empty message (0x80000000 then zeros), single then double mode -> E3B0C44298FC1C149AFBF4C8996FB92427AE41E4649B934CA495991B7852B855 and 5DF6E0E2761359D30A8275058E299FCC0381534545F55CF43E41983F5D4C9456, for every legal UNROLL.
REQ-033 SHALL cover: out_ready held low 10 cycles after valid_out -> digest_out and valid_out stable for those cycles, then one-cycle consumption, then in_ready rises one cycle later.
REQ-034 SHALL cover: flush asserted in the 20th ROUND cycle with in_valid high -> IDLE next edge, no valid_out; the next job's digest is correct.
REQ-035 SHALL cover: RST driven low mid pass 2 -> valid_out=0 and in_ready=0 immediately without a clock edge; a job after release yields the correct digest.
